// File: rtl/sim_run_ctrl_if.sv
// Core-side io write bus seen by the run controller: one-cycle write strobe,
// full-width address and the low data byte.
interface sim_run_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  io_wr;
    logic [ADDR_WIDTH-1:0] io_addr;
    logic [7:0]            io_data;

    modport master (
        output io_wr,
        output io_addr,
        output io_data
    );

    modport slave (
        input io_wr,
        input io_addr,
        input io_data
    );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run controller: stretches reset into core reset, counts run cycles and UART writes,
// ends the run on a halt write or watchdog. SIM_RUN_TRACE_EN adds simulation-only trace/$finish.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  HOLD      | core held in reset while the hold counter runs
//  RUN       | core released, cycle/tx counters active, halt/watchdog armed
//  HALTED    | program wrote the halt address; terminal until rst
//  TIMED_OUT | watchdog expired; terminal until rst
module sim_run_ctrl #(
    parameter int                    RST_CYCLES = 25,
    parameter int                    CNT_WIDTH  = 32,
    parameter int                    TIMEOUT    = 0,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR  = 'h30004,
    parameter logic [ADDR_WIDTH-1:0] UART_ADDR  = 'h30000
) (
    input  logic                 clk,
    input  logic                 rst,
    sim_run_ctrl_if.slave        io,
    output logic                 core_rst_o,
    output logic                 running_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [7:0]           exit_code_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o,
    output logic [CNT_WIDTH-1:0] tx_cnt_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        RUN       = 2'd1,
        HALTED    = 2'd2,
        TIMED_OUT = 2'd3
    } state_t;

    localparam int RST_MAX = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
    localparam int HOLD_W  = $clog2(RST_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_MAX - 1);

    // A limit that cannot be represented in CNT_WIDTH can never be reached, so it disables the watchdog.
    localparam bit WDOG_EN = (TIMEOUT > 0) && ((64'(TIMEOUT) >> CNT_WIDTH) == 64'd0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   core_rst_q, core_rst_d;
    logic                   running_q, running_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic [7:0]             exit_q, exit_d;
    logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]   tx_q, tx_d;

    logic                   wr_halt;
    logic                   wr_uart;
    logic [CNT_WIDTH-1:0]   cycle_inc;
    logic [CNT_WIDTH-1:0]   tx_inc;

    assign wr_halt   = io.io_wr && (io.io_addr == HALT_ADDR);
    assign wr_uart   = io.io_wr && (io.io_addr == UART_ADDR);
    assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + CNT_WIDTH'(1);
    assign tx_inc    = (tx_q == '1) ? tx_q : tx_q + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HOLD;
            hold_q     <= '0;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            exit_q     <= 8'h00;
            cycle_q    <= '0;
            tx_q       <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            core_rst_q <= core_rst_d;
            running_q  <= running_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            exit_q     <= exit_d;
            cycle_q    <= cycle_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        core_rst_d = core_rst_q;
        running_d  = running_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        exit_d     = exit_q;
        cycle_d    = cycle_q;
        tx_d       = tx_q;

        case (state_q)
            HOLD: begin
                core_rst_d = 1'b1;
                running_d  = 1'b0;
                hold_d     = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_LAST) begin
                    state_d    = RUN;
                    core_rst_d = 1'b0;
                    running_d  = 1'b1;
                end
            end

            RUN: begin
                cycle_d = cycle_inc;
                if (wr_uart) begin
                    tx_d = tx_inc;
                end
                // Halt is checked first so a halt on the watchdog edge leaves timeout clear.
                if (wr_halt) begin
                    state_d    = HALTED;
                    exit_d     = io.io_data;
                    done_d     = 1'b1;
                    running_d  = 1'b0;
                    core_rst_d = 1'b1;
                end else if (WDOG_EN && (cycle_inc == TIMEOUT_VAL)) begin
                    state_d    = TIMED_OUT;
                    timeout_d  = 1'b1;
                    exit_d     = 8'hFF;
                    done_d     = 1'b1;
                    running_d  = 1'b0;
                    core_rst_d = 1'b1;
                end
            end

            default: begin
                core_rst_d = 1'b1;
                running_d  = 1'b0;
            end
        endcase
    end

    assign core_rst_o  = core_rst_q;
    assign running_o   = running_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign exit_code_o = exit_q;
    assign cycle_cnt_o = cycle_q;
    assign tx_cnt_o    = tx_q;
    assign state_o     = state_q;

`ifdef SIM_RUN_TRACE_EN
    logic done_prev_q;

    always @(posedge clk) begin
        if (!rst && (state_q == RUN) && (state_d == HALTED)) begin
            $display("[%0t] sim_run_ctrl: halted cycles=%0d tx=%0d exit=0x%02h",
                     $time, cycle_d, tx_d, exit_d);
        end
        if (!rst && (state_q == RUN) && (state_d == TIMED_OUT)) begin
            $display("[%0t] sim_run_ctrl: watchdog timeout at cycle %0d", $time, cycle_d);
        end
        if (!rst && done_q && !done_prev_q) begin
            $finish;
        end
        done_prev_q <= rst ? 1'b0 : done_q;
    end
`else
    // Synthesis build: no trace hooks, outputs are identical.
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Self-checking bench for sim_run_ctrl: four parameterisations driven from a vector table
// through a scoreboard queue, plus a cycle-by-cycle check of the reset hold window.
module tb_sim_run_ctrl;

    localparam logic [31:0] A_UART  = 32'h30000;
    localparam logic [31:0] A_HALT  = 32'h30004;
    localparam logic [31:0] A_OTHER = 32'h30008;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       rst_v;
    logic [3:0]       wr_v;
    logic [3:0][31:0] addr_v;
    logic [3:0][7:0]  data_v;

    wire  [3:0]       cr_w, rn_w, dn_w, to_w;
    wire  [3:0][7:0]  ex_w;
    wire  [3:0][1:0]  st_w;
    wire  [3:0][31:0] cy_w, tx_w;
    wire  [3:0]       cy_c, tx_c;

    sim_run_ctrl_if #(.ADDR_WIDTH(32)) if0 ();
    sim_run_ctrl_if #(.ADDR_WIDTH(32)) if1 ();
    sim_run_ctrl_if #(.ADDR_WIDTH(32)) if2 ();
    sim_run_ctrl_if #(.ADDR_WIDTH(32)) if3 ();

    assign if0.io_wr = wr_v[0];  assign if0.io_addr = addr_v[0];  assign if0.io_data = data_v[0];
    assign if1.io_wr = wr_v[1];  assign if1.io_addr = addr_v[1];  assign if1.io_data = data_v[1];
    assign if2.io_wr = wr_v[2];  assign if2.io_addr = addr_v[2];  assign if2.io_data = data_v[2];
    assign if3.io_wr = wr_v[3];  assign if3.io_addr = addr_v[3];  assign if3.io_data = data_v[3];

    sim_run_ctrl #(.RST_CYCLES(25)) u_a (
        .clk(clk), .rst(rst_v[0]), .io(if0),
        .core_rst_o(cr_w[0]), .running_o(rn_w[0]), .done_o(dn_w[0]), .timeout_o(to_w[0]),
        .exit_code_o(ex_w[0]), .cycle_cnt_o(cy_w[0]), .tx_cnt_o(tx_w[0]), .state_o(st_w[0])
    );

    sim_run_ctrl #(.RST_CYCLES(0), .TIMEOUT(50)) u_b (
        .clk(clk), .rst(rst_v[1]), .io(if1),
        .core_rst_o(cr_w[1]), .running_o(rn_w[1]), .done_o(dn_w[1]), .timeout_o(to_w[1]),
        .exit_code_o(ex_w[1]), .cycle_cnt_o(cy_w[1]), .tx_cnt_o(tx_w[1]), .state_o(st_w[1])
    );

    sim_run_ctrl #(.RST_CYCLES(3), .CNT_WIDTH(4)) u_c (
        .clk(clk), .rst(rst_v[2]), .io(if2),
        .core_rst_o(cr_w[2]), .running_o(rn_w[2]), .done_o(dn_w[2]), .timeout_o(to_w[2]),
        .exit_code_o(ex_w[2]), .cycle_cnt_o(cy_c), .tx_cnt_o(tx_c), .state_o(st_w[2])
    );
    assign cy_w[2] = {28'd0, cy_c};
    assign tx_w[2] = {28'd0, tx_c};

    sim_run_ctrl #(.RST_CYCLES(1), .HALT_ADDR(32'h30000), .UART_ADDR(32'h30000)) u_d (
        .clk(clk), .rst(rst_v[3]), .io(if3),
        .core_rst_o(cr_w[3]), .running_o(rn_w[3]), .done_o(dn_w[3]), .timeout_o(to_w[3]),
        .exit_code_o(ex_w[3]), .cycle_cnt_o(cy_w[3]), .tx_cnt_o(tx_w[3]), .state_o(st_w[3])
    );

    typedef struct {
        string       name;
        int          d;
        logic [1:0]  st;
        logic        cr, rn, dn, to;
        logic [7:0]  ex;
        logic [31:0] cy, tx;
    } exp_t;

    typedef struct {
        int          d;
        logic        r, w;
        logic [31:0] a;
        logic [7:0]  dt;
        int          reps;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(string nm, int d, logic r, logic w, logic [31:0] a,
                                logic [7:0] dt, int reps, logic [1:0] st, logic cr,
                                logic rn, logic dn, logic to, logic [7:0] ex,
                                logic [31:0] cy, logic [31:0] tx);
        vec_t v;
        v.d = d; v.r = r; v.w = w; v.a = a; v.dt = dt; v.reps = reps;
        v.e.name = nm; v.e.d = d; v.e.st = st; v.e.cr = cr; v.e.rn = rn;
        v.e.dn = dn; v.e.to = to; v.e.ex = ex; v.e.cy = cy; v.e.tx = tx;
        vecs.push_back(v);
    endfunction

    task automatic step(int d, logic r, logic w, logic [31:0] a, logic [7:0] dt);
        @(negedge clk);
        rst_v[d]  = r;
        wr_v[d]   = w;
        addr_v[d] = a;
        data_v[d] = dt;
        @(posedge clk);
        #1;
    endtask

    task automatic check_top();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard: empty queue at check");
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if ({st_w[e.d], cr_w[e.d], rn_w[e.d], dn_w[e.d], to_w[e.d], ex_w[e.d], cy_w[e.d], tx_w[e.d]} !==
            {e.st, e.cr, e.rn, e.dn, e.to, e.ex, e.cy, e.tx}) begin
            n_bad++;
            $display("FAIL %s: got st=%0d cr=%0b run=%0b done=%0b to=%0b ex=%02h cyc=%0d tx=%0d, want st=%0d cr=%0b run=%0b done=%0b to=%0b ex=%02h cyc=%0d tx=%0d",
                     e.name, st_w[e.d], cr_w[e.d], rn_w[e.d], dn_w[e.d], to_w[e.d], ex_w[e.d],
                     cy_w[e.d], tx_w[e.d], e.st, e.cr, e.rn, e.dn, e.to, e.ex, e.cy, e.tx);
        end
    endtask

    initial begin
        rst_v  = 4'hF;
        wr_v   = 4'h0;
        addr_v = '0;
        data_v = '0;

        // name, dut, rst, wr, addr, data, reps | st, core_rst, running, done, timeout, exit, cycle, tx
        add("a_rst",         0, 1, 0, 0,       8'h00,  3, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("a_hold_uart",   0, 0, 1, A_UART,  8'h41,  3, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("a_hold_end",    0, 0, 0, 0,       8'h00, 21, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("a_run_entry",   0, 0, 0, 0,       8'h00,  1, 1, 0, 1, 0, 0, 8'h00,   0, 0);
        add("a_run_first",   0, 0, 0, 0,       8'h00,  1, 1, 0, 1, 0, 0, 8'h00,   1, 0);
        add("a_uart5",       0, 0, 1, A_UART,  8'h42,  5, 1, 0, 1, 0, 0, 8'h00,   6, 5);
        add("a_other2",      0, 0, 1, A_OTHER, 8'h43,  2, 1, 0, 1, 0, 0, 8'h00,   8, 5);
        add("a_run100",      0, 0, 0, 0,       8'h00, 92, 1, 0, 1, 0, 0, 8'h00, 100, 5);
        add("a_halt",        0, 0, 1, A_HALT,  8'h2A,  1, 2, 1, 0, 1, 0, 8'h2A, 101, 5);
        add("a_frozen_uart", 0, 0, 1, A_UART,  8'h44,  3, 2, 1, 0, 1, 0, 8'h2A, 101, 5);
        add("a_frozen_halt", 0, 0, 1, A_HALT,  8'h55,  2, 2, 1, 0, 1, 0, 8'h2A, 101, 5);
        add("a_rst2",        0, 1, 0, 0,       8'h00,  1, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("a_rehold",      0, 0, 0, 0,       8'h00, 24, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("a_rerun",       0, 0, 0, 0,       8'h00,  1, 1, 0, 1, 0, 0, 8'h00,   0, 0);
        add("a_run40",       0, 0, 1, A_UART,  8'h45, 40, 1, 0, 1, 0, 0, 8'h00,  40, 40);
        add("a_midrst",      0, 1, 0, 0,       8'h00,  1, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("a_replay_hold", 0, 0, 0, 0,       8'h00, 24, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("a_replay_run",  0, 0, 0, 0,       8'h00,  1, 1, 0, 1, 0, 0, 8'h00,   0, 0);

        add("b_rst",         1, 1, 0, 0,       8'h00,  2, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("b_run_entry",   1, 0, 0, 0,       8'h00,  1, 1, 0, 1, 0, 0, 8'h00,   0, 0);
        add("b_run49",       1, 0, 0, 0,       8'h00, 49, 1, 0, 1, 0, 0, 8'h00,  49, 0);
        add("b_timeout",     1, 0, 0, 0,       8'h00,  1, 3, 1, 0, 1, 1, 8'hFF,  50, 0);
        add("b_frozen",      1, 0, 1, A_UART,  8'h46,  3, 3, 1, 0, 1, 1, 8'hFF,  50, 0);
        add("b_rst2",        1, 1, 0, 0,       8'h00,  1, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("b_run_entry2",  1, 0, 0, 0,       8'h00,  1, 1, 0, 1, 0, 0, 8'h00,   0, 0);
        add("b_run49b",      1, 0, 0, 0,       8'h00, 49, 1, 0, 1, 0, 0, 8'h00,  49, 0);
        add("b_halt_tie",    1, 0, 1, A_HALT,  8'h00,  1, 2, 1, 0, 1, 0, 8'h00,  50, 0);

        add("c_rst",         2, 1, 0, 0,       8'h00,  1, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("c_hold",        2, 0, 0, 0,       8'h00,  2, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("c_run_entry",   2, 0, 0, 0,       8'h00,  1, 1, 0, 1, 0, 0, 8'h00,   0, 0);
        add("c_cy15",        2, 0, 0, 0,       8'h00, 15, 1, 0, 1, 0, 0, 8'h00,  15, 0);
        add("c_sat",         2, 0, 1, A_UART,  8'h47, 20, 1, 0, 1, 0, 0, 8'h00,  15, 15);

        add("d_rst",         3, 1, 0, 0,       8'h00,  1, 0, 1, 0, 0, 0, 8'h00,   0, 0);
        add("d_run",         3, 0, 0, 0,       8'h00,  1, 1, 0, 1, 0, 0, 8'h00,   0, 0);
        add("d_both",        3, 0, 1, A_UART,  8'h07,  1, 2, 1, 0, 1, 0, 8'h07,   1, 1);

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                if (r == vecs[i].reps - 1) sb.push_back(vecs[i].e);
                step(vecs[i].d, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].dt);
            end
            check_top();
        end

        // Every edge of DUT A's hold window: core_rst high through edge 24, released on 25.
        step(0, 1'b1, 1'b0, 32'd0, 8'h00);
        step(0, 1'b1, 1'b0, 32'd0, 8'h00);
        for (int i = 1; i <= 26; i++) begin
            exp_t e;
            e.name = $sformatf("a_hold_edge%0d", i);
            e.d  = 0;
            e.st = (i >= 25) ? 2'd1 : 2'd0;
            e.cr = (i < 25);
            e.rn = (i >= 25);
            e.dn = 1'b0;
            e.to = 1'b0;
            e.ex = 8'h00;
            e.cy = (i == 26) ? 32'd1 : 32'd0;
            e.tx = 32'd0;
            sb.push_back(e);
            step(0, 1'b0, 1'b0, 32'd0, 8'h00);
            check_top();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
